// File: rtl/magic_nor_sequencer_if.sv
// magic_nor_sequencer_if
// Bundles the program-load, cell-access, run-control and status signals of
// the MAGIC NOR sequencer.
//   master : the controller driving programs/inputs and reading results
//   slave  : the sequencer itself
// Signals:
//   prog_we/prog_addr/prog_data : program slot write (gate words)
//   prog_len/start              : run request and gate count
//   in_we/in_addr/in_data       : primary-input cell write
//   rd_addr/rd_data             : combinational cell readout
//   busy/done/err               : run status
//   dbg_state                   : current FSM state (IDLE=0 INIT=1 EVAL=2 FIN=3)
interface magic_nor_sequencer_if;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        in_we;
    logic [4:0]  in_addr;
    logic        in_data;
    logic [4:0]  rd_addr;
    logic        rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start,
        output in_we, in_addr, in_data, rd_addr,
        input  rd_data, busy, done, err, dbg_state
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start,
        input  in_we, in_addr, in_data, rd_addr,
        output rd_data, busy, done, err, dbg_state
    );
endinterface

// File: rtl/magic_nor_sequencer.sv
// magic_nor_sequencer
// Sequences a stored program of INV / NOR2 gates over a 1-bit memristive
// crossbar model. Each gate takes two cycles: INIT pre-sets the output cell
// to 1 (MAGIC requirement), EVAL writes the gate result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears FSM, cells and program)
//   bus   : magic_nor_sequencer_if.slave (program, cell, run, status signals)
// Gate word: [15] op (0=INV, 1=NOR2), [14:10] src A, [9:5] src B, [4:0] dst.
//
// Run handshake: start is a one-cycle request that is only looked at in
// IDLE; there is no ready signal, so a start seen in any other state is
// dropped. An accepted run is acknowledged by busy rising on the next cycle
// (or, for an empty program, by done directly), and ends with a single-cycle
// done pulse. err is sticky until the next accepted start.
module magic_nor_sequencer #(
    parameter int NCELL = 32,
    parameter int NPROG = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    magic_nor_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_EVAL = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                      state_q;
    logic [4:0]                  pc_q;
    logic [4:0]                  len_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;
    logic [NCELL-1:0]            cells_q;
    logic [NPROG-1:0][15:0]      prog_q;

    // Decoded fields of the gate currently addressed by pc.
    logic [15:0] word;
    logic        op;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  dst;
    logic        conflict;
    logic        last_gate;

    assign word      = prog_q[pc_q[3:0]];
    assign op        = word[15];
    assign src_a     = word[14:10];
    assign src_b     = word[9:5];
    assign dst       = word[4:0];
    // The output cell is pre-set before evaluation, so it must not also be
    // an operand or the operand value would be destroyed.
    assign conflict  = (dst == src_a) || (op && (dst == src_b));
    assign last_gate = (pc_q == (len_q - 5'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cells_q <= '0;
            prog_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Loads happen on the same edge as an accepted start, so
                    // the run sees both the new slot contents and new inputs.
                    if (bus.in_we) begin
                        cells_q[bus.in_addr] <= bus.in_data;
                    end
                    if (bus.prog_we) begin
                        prog_q[bus.prog_addr] <= bus.prog_data;
                    end
                    if (bus.start) begin
                        if (bus.prog_len == 5'd0) begin
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else if (bus.prog_len > 5'(NPROG)) begin
                            err_q   <= 1'b1;
                        end else begin
                            len_q   <= bus.prog_len;
                            pc_q    <= '0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    if (conflict) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        cells_q[dst] <= 1'b1;
                        state_q      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Operands are read from the registered array, i.e. the
                    // values at the start of this cycle.
                    if (op) begin
                        cells_q[dst] <= ~(cells_q[src_a] | cells_q[src_b]);
                    end else begin
                        cells_q[dst] <= ~cells_q[src_a];
                    end
                    if (last_gate) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        pc_q    <= pc_q + 5'd1;
                        state_q <= S_INIT;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data   = cells_q[bus.rd_addr];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// tb_magic_nor_sequencer
// Directed bench for magic_nor_sequencer: hand-computed expectations for
// gate results, busy/done timing, error handling and asynchronous reset.
module tb_magic_nor_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   busy_cnt;
    int   done_cnt;
    int   done_at;

    // Expected cell readouts: {addr[4:0], value}
    logic [5:0] exp_q[$];

    magic_nor_sequencer_if bus ();

    magic_nor_sequencer #(.NCELL(32), .NPROG(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gw(input logic op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
        return {op, a, b, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_cell(input logic [4:0] a, input logic v);
        bus.in_we   = 1'b1;
        bus.in_addr = a;
        bus.in_data = v;
        @(negedge clk);
        bus.in_we   = 1'b0;
    endtask

    task automatic write_prog(input logic [3:0] s, input logic [15:0] w);
        bus.prog_we   = 1'b1;
        bus.prog_addr = s;
        bus.prog_data = w;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic v);
        bus.rd_addr = a;
        #1;
        v = bus.rd_data;
    endtask

    task automatic expect_cell(input logic [4:0] a, input logic v);
        exp_q.push_back({a, v});
    endtask

    // Compare every queued expected cell against the crossbar readout.
    task automatic drain_cells(input string tag);
        logic [5:0] e;
        logic       v;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd(e[5:1], v);
            check($sformatf("%s_c%0d", tag, e[5:1]), v, e[0]);
        end
    endtask

    // Issue start (together with any strobes already set up by the caller)
    // and observe a fixed 40-cycle window. Cycle k=1 is the first cycle after
    // the edge that samples start. With poke set, start/in_we/prog_we are
    // pulsed during the run and must be ignored.
    task automatic run(input logic [4:0] n, input bit poke);
        bus.prog_len = n;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.in_we   = 1'b0;
        bus.prog_we = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (poke && k == 2) begin
                bus.start     = 1'b1;
                bus.prog_len  = 5'd1;
                bus.in_we     = 1'b1;
                bus.in_addr   = 5'd7;
                bus.in_data   = 1'b1;
                bus.prog_we   = 1'b1;
                bus.prog_addr = 4'd1;
                bus.prog_data = gw(1'b0, 5'd5, 5'd0, 5'd15);
            end else if (poke && k == 3) begin
                bus.start   = 1'b0;
                bus.in_we   = 1'b0;
                bus.prog_we = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n         = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.in_we     = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = 1'b0;
        bus.rd_addr   = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_state", bus.dbg_state, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_cell(5'd0, 1'b0);
        expect_cell(5'd31, 1'b0);
        drain_cells("rst");

        // Single NOR2: c0=1,c1=0 -> c2 = 0
        write_cell(5'd0, 1'b1);
        write_prog(4'd0, gw(1'b1, 5'd0, 5'd1, 5'd2));
        run(5'd1, 1'b0);
        check("nor1_busy", busy_cnt, 2);
        check("nor1_done_at", done_at, 3);
        check("nor1_done_cnt", done_cnt, 1);
        check("nor1_err", bus.err, 1'b0);
        expect_cell(5'd2, 1'b0);
        expect_cell(5'd0, 1'b1);
        expect_cell(5'd1, 1'b0);
        drain_cells("nor1");

        // Chain INV c3->c4, NOR2 c4,c5->c6 with pokes during busy
        write_prog(4'd0, gw(1'b0, 5'd3, 5'd0, 5'd4));
        write_prog(4'd1, gw(1'b1, 5'd4, 5'd5, 5'd6));
        run(5'd2, 1'b1);
        check("chain_busy", busy_cnt, 4);
        check("chain_done_at", done_at, 5);
        check("chain_done_cnt", done_cnt, 1);
        expect_cell(5'd4, 1'b1);
        expect_cell(5'd6, 1'b0);
        expect_cell(5'd7, 1'b0);
        expect_cell(5'd15, 1'b0);
        drain_cells("chain");

        // NOR2 of two zeros -> 1, INV of one -> 0 (overwrites INIT pre-set)
        write_prog(4'd0, gw(1'b1, 5'd1, 5'd5, 5'd8));
        write_prog(4'd1, gw(1'b0, 5'd0, 5'd0, 5'd9));
        run(5'd2, 1'b0);
        check("mix_done_at", done_at, 5);
        expect_cell(5'd8, 1'b1);
        expect_cell(5'd9, 1'b0);
        drain_cells("mix");

        // dst == A -> error after INIT, dst unchanged
        write_cell(5'd10, 1'b1);
        write_prog(4'd0, gw(1'b1, 5'd10, 5'd1, 5'd10));
        run(5'd1, 1'b0);
        check("errA_err", bus.err, 1'b1);
        check("errA_busy", busy_cnt, 1);
        check("errA_done_at", done_at, 2);
        check("errA_done_cnt", done_cnt, 1);
        expect_cell(5'd10, 1'b1);
        drain_cells("errA");

        // NOR2 dst == B -> error, pre-set must not land
        write_prog(4'd0, gw(1'b1, 5'd1, 5'd11, 5'd11));
        run(5'd1, 1'b0);
        check("errB_err", bus.err, 1'b1);
        expect_cell(5'd11, 1'b0);
        drain_cells("errB");

        // INV ignores B, so dst == B is legal; valid start clears err
        write_prog(4'd0, gw(1'b0, 5'd1, 5'd13, 5'd13));
        run(5'd1, 1'b0);
        check("invB_err", bus.err, 1'b0);
        check("invB_done_at", done_at, 3);
        expect_cell(5'd13, 1'b1);
        drain_cells("invB");

        // prog_len = 17: error, nothing happens
        run(5'd17, 1'b0);
        check("len17_err", bus.err, 1'b1);
        check("len17_done_cnt", done_cnt, 0);
        check("len17_busy", busy_cnt, 0);
        check("len17_state", bus.dbg_state, 2'd0);
        expect_cell(5'd13, 1'b1);
        expect_cell(5'd8, 1'b1);
        expect_cell(5'd2, 1'b0);
        drain_cells("len17");

        // prog_len = 0: done at t+1, no busy, err cleared
        run(5'd0, 1'b0);
        check("len0_err", bus.err, 1'b0);
        check("len0_done_at", done_at, 1);
        check("len0_done_cnt", done_cnt, 1);
        check("len0_busy", busy_cnt, 0);

        // prog_len = 16: full program depth
        for (int s = 0; s < 16; s++) begin
            write_prog(s[3:0], gw(1'b0, 5'd20, 5'd0, 5'd21));
        end
        run(5'd16, 1'b0);
        check("len16_busy", busy_cnt, 32);
        check("len16_done_at", done_at, 33);
        check("len16_err", bus.err, 1'b0);
        expect_cell(5'd21, 1'b1);
        drain_cells("len16");

        // Same-cycle prog_we + in_we + start
        write_prog(4'd0, gw(1'b0, 5'd24, 5'd0, 5'd22));
        write_cell(5'd23, 1'b1);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = gw(1'b0, 5'd23, 5'd0, 5'd25);
        bus.in_we     = 1'b1;
        bus.in_addr   = 5'd23;
        bus.in_data   = 1'b0;
        run(5'd1, 1'b0);
        check("same_done_at", done_at, 3);
        expect_cell(5'd25, 1'b1);
        expect_cell(5'd22, 1'b0);
        expect_cell(5'd23, 1'b0);
        drain_cells("same");

        // Asynchronous reset during EVAL of a 4-gate run
        write_cell(5'd26, 1'b1);
        for (int s = 0; s < 4; s++) begin
            write_prog(s[3:0], gw(1'b0, 5'd26, 5'd0, 5'(27 + s)));
        end
        bus.prog_len = 5'd4;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("arst_pre_state", bus.dbg_state, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_state", bus.dbg_state, 2'd0);
        expect_cell(5'd26, 1'b0);
        expect_cell(5'd27, 1'b0);
        expect_cell(5'd13, 1'b0);
        drain_cells("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Slot 0 was cleared: all-zero word is INV c0->c0, an error
        run(5'd1, 1'b0);
        check("arst_slot0_err", bus.err, 1'b1);
        check("arst_slot0_done_at", done_at, 2);

        // Fresh program after reset: NOR2 c1,c2 -> c3 = 1
        write_prog(4'd0, gw(1'b1, 5'd1, 5'd2, 5'd3));
        run(5'd1, 1'b0);
        check("fresh_err", bus.err, 1'b0);
        check("fresh_busy", busy_cnt, 2);
        check("fresh_done_at", done_at, 3);
        expect_cell(5'd3, 1'b1);
        drain_cells("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magic_nor_sequencer.md
MAGIC_NOR_SEQUENCER -- requirements
Module: magic_nor_sequencer

Interface
REQ-001 SHALL have parameter NCELL, default 32, number of 1-bit crossbar cells (fixed 32 in this revision; 5-bit cell addresses).
REQ-002 SHALL have parameter NPROG, default 16, program memory depth (4-bit slot addresses).
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port prog_we, input, 1, program slot write strobe.
REQ-006 SHALL have port prog_addr, input, 4, program slot index.
REQ-007 SHALL have port prog_data, input, 16, gate word: [15] op (0=INV, 1=NOR2), [14:10] src A, [9:5] src B, [4:0] dst.
REQ-008 SHALL have port prog_len, input, 5, gate count to execute, sampled at start.
REQ-009 SHALL have port start, input, 1, run request.
REQ-010 SHALL have port in_we, input, 1, cell write strobe for primary inputs.
REQ-011 SHALL have port in_addr, input, 5, cell index for in_we.
REQ-012 SHALL have port in_data, input, 1, value for in_we.
REQ-013 SHALL have port rd_addr, input, 5, cell readout index.
REQ-014 SHALL have port rd_data, output, 1, combinational cells[rd_addr].
REQ-015 SHALL have port busy, output, 1, high in INIT/EVAL.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port err, output, 1, sticky error flag.

Function
REQ-018 SHALL implement FSM states IDLE, INIT, EVAL, FIN; gate index pc (5 bits) and latched length len.
REQ-019 IDLE: start=1 with prog_len in 1..16 SHALL latch len, pc=0, clear err, go INIT.
REQ-020 IDLE: start=1 with prog_len=0 SHALL clear err, go FIN, write no cell.
REQ-021 IDLE: start=1 with prog_len>16 SHALL set err, stay IDLE, write no cell, no done.
REQ-022 INIT: SHALL write cells[dst(pc)]=1 (MAGIC output pre-set), go EVAL.
REQ-023 INIT: dst equal to src A, or (op=NOR2) dst equal to src B, SHALL set err, write nothing, go FIN.
REQ-024 EVAL: SHALL write cells[dst]=~cells[A] (INV) or ~(cells[A]|cells[B]) (NOR2), using cell values as of that cycle's start.
REQ-025 EVAL: pc==len-1 SHALL go FIN, else pc+1 and go INIT.
REQ-026 FIN: SHALL assert done for exactly that cycle, go IDLE.
REQ-027 Latency: start accepted at edge t with len=N, no error SHALL give busy high for cycles t+1..t+2N and done at cycle t+2N+1.
REQ-028 start, prog_we, in_we while not IDLE SHALL be ignored.
REQ-029 In IDLE, in_we and prog_we SHALL take effect at the clock edge; if in_we coincides with an accepted start, the write SHALL land before the first EVAL.
REQ-030 Same-cycle prog_we and start in IDLE: the program write SHALL complete; execution SHALL use the updated slot.
REQ-031 err SHALL stay high until the next accepted start clears it.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, pc=0, len=0, busy=0, done=0, err=0, all cells 0, all program slots 0, regardless of operation in progress.
REQ-033 Release of rst_n SHALL resume in IDLE; the first start SHALL be accepted no earlier than the first rising edge with rst_n high.

Verification
REQ-034 Cells c0=1,c1=0; slot0={NOR2,A=0,B=1,dst=2}; start, len=1 -> busy 2 cycles, done at t+3, rd_data(c2)=0.
REQ-035 Chain INV c3->c4, NOR2 c4,c5->c6 with c3=0,c5=0, len=2 -> c4=1, c6=0, busy exactly 4 cycles, done once.
REQ-036 Slot with dst=A, len=1 -> err=1, done pulse after INIT, dst cell unchanged; next valid start clears err.
REQ-037 prog_len=0 -> done at t+1, busy never high; prog_len=17 -> err=1, no done, cells unchanged.
REQ-038 rst_n low during EVAL of a 4-gate run -> busy=0, done=0, all cells and slots 0 asynchronously; fresh program after release runs correctly.
REQ-039 start and in_we pulsed during busy -> no effect on state, cells, or done timing.
